instr_register_ctrl: RTL and testbench
======================================

Name: instr_register_ctrl

Overview:
Write/read sequencer and 2-requester arbiter in front of the instr_register datapath. It accepts instructions (opcode, operand_a, operand_b) from two requesters over valid/ready and arbitrates between them round-robin. It drives load_en, write_pointer and the operands into the register, and manages read_pointer as an in-order FIFO cursor toward a single consumer. It tracks occupancy so the register file never overwrites an unread entry.

Parameters:
DEPTH, 32, number of register entries; power of 2 required.
ADDR_W, 5, log2(DEPTH); width of the pointers.
OPC_W, 4, opcode width (opcode_t).
OPD_W, 32, operand width (operand_t, signed).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of pointers and occupancy.
req0_valid  in  1  requester 0 has an instruction.
req0_ready  out  1  requester 0 instruction accepted this cycle.
req0_opcode  in  OPC_W  requester 0 opcode.
req0_operand_a  in  OPD_W  requester 0 operand A.
req0_operand_b  in  OPD_W  requester 0 operand B.
req1_valid, req1_ready, req1_opcode, req1_operand_a, req1_operand_b: same as requester 0, for requester 1.
load_en  out  1  write strobe to instr_register.
opcode  out  OPC_W  opcode to instr_register.
operand_a  out  OPD_W  operand A to instr_register.
operand_b  out  OPD_W  operand B to instr_register.
write_pointer  out  ADDR_W  write address to instr_register.
read_pointer  out  ADDR_W  read address to instr_register.
rd_valid  out  1  entry at read_pointer is valid (instruction_word usable).
rd_ready  in  1  consumer takes the entry this cycle.
count  out  ADDR_W+1  committed entries, 0..DEPTH.
full  out  1  count == DEPTH.
empty  out  1  count == 0.

Behaviour:
- Reset: all state registers asynchronous on reset_n low.
  - Reset values: load_en=0, opcode=0, operand_a=0, operand_b=0, write_pointer=0, read_pointer=0, count=0, empty=1, full=0, rd_valid=0, rr_prio=req0.
  - req0_ready and req1_ready are 0 while reset_n is low.
- Accept condition: can_accept = !flush && (count + load_en) < DEPTH. Pending pops are ignored (conservative).
- Arbitration (combinational, same cycle):
  - Only one valid: that requester is granted if can_accept.
  - Both valid: the requester indicated by rr_prio is granted.
  - reqN_ready = can_accept && grant==N. At most one ready per cycle.
  - Ready may depend on valid; valid must not depend on ready.
- After any grant to N, rr_prio is set to the other requester at the edge. With no grant, rr_prio holds.
- Write stage (registered):
  - A handshake at edge E loads opcode, operand_a and operand_b from the granted requester and sets load_en=1 for the cycle after E. write_pointer = wr_ptr.
  - At edge E+1 the register writes the entry, then wr_ptr increments and count increments.
  - With no handshake at E, load_en=0 after E. opcode and operands hold their last value.
  - Throughput: 1 accept per cycle; back-to-back grants keep load_en high continuously.
- Read side:
  - rd_valid = !empty. read_pointer = rd_ptr.
  - A pop (rd_valid && rd_ready) at an edge increments rd_ptr and decrements count.
  - rd_ready while empty is ignored.
- Latency: an accepted instruction becomes visible (rd_valid, instruction_word at read_pointer) 2 cycles after its handshake edge, i.e. after edge E+1.
- Pointers wrap DEPTH-1 -> 0 modulo DEPTH.
- Simultaneous write commit and pop: count unchanged, both pointers advance.
- full is asserted when count==DEPTH. can_accept is already 0 when count==DEPTH-1 and load_en==1.
- flush at an edge:
  - wr_ptr, rd_ptr, count <- 0 and load_en <- 0; rr_prio is unchanged.
  - Both readys are 0 during the flush cycle.
  - Any write occurring at that edge is logically discarded.
- Reset mid-operation: all state returns to reset values immediately. An in-flight load_en drops asynchronously.

Test Plan:
- Reset then idle:
  - Check all outputs at reset values; empty=1, rd_valid=0, readys=0.
  - After release with no valid, load_en stays 0.
- Single write:
  - req0 (opcode=3, a=5, b=-2) accepted at edge E -> load_en=1, write_pointer=0 in cycle E..E+1.
  - After E+1: count=1, rd_valid=1, read_pointer=0, instruction_word holds {3,5,-2}.
- Round-robin:
  - Both valid every cycle for 4 cycles -> grants req0, req1, req0, req1.
  - write_pointer 0,1,2,3; load_en continuously high.
- Fill to full:
  - 32 writes with rd_ready=0 -> count=32, full=1, readys=0.
  - 33rd instruction held until one pop, then accepted into write_pointer=0 (wrap).
- Simultaneous write and pop at count=10 -> count stays 10; write_pointer and read_pointer each +1. Pop at read_pointer=31 wraps to 0.
- Flush and reset:
  - flush at count=7 with load_en high -> next cycle count=0, both pointers 0, empty=1.
  - reset_n low mid-burst -> load_en=0 immediately.

Source files
------------

// File: rtl/instr_register_ctrl_if.sv
// ---------------------------------------------------------------------------
// instr_register_ctrl_if
// Bundles every handshake and datapath signal around instr_register_ctrl.
//   req0_* / req1_*   : two instruction requesters (valid/ready, opcode,
//                       operand_a, operand_b)
//   load_en, opcode, operand_a, operand_b, write_pointer
//                     : write port toward the instr_register datapath
//   read_pointer, rd_valid, rd_ready
//                     : in-order read cursor toward the single consumer
//   count, full, empty: occupancy status
// modport master : requesters + consumer side (drives valid/payload/rd_ready)
// modport slave  : the controller
// ---------------------------------------------------------------------------
interface instr_register_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 4,
    parameter int OPD_W  = 32
);
    logic                     req0_valid;
    logic                     req0_ready;
    logic [OPC_W-1:0]         req0_opcode;
    logic signed [OPD_W-1:0]  req0_operand_a;
    logic signed [OPD_W-1:0]  req0_operand_b;

    logic                     req1_valid;
    logic                     req1_ready;
    logic [OPC_W-1:0]         req1_opcode;
    logic signed [OPD_W-1:0]  req1_operand_a;
    logic signed [OPD_W-1:0]  req1_operand_b;

    logic                     load_en;
    logic [OPC_W-1:0]         opcode;
    logic signed [OPD_W-1:0]  operand_a;
    logic signed [OPD_W-1:0]  operand_b;
    logic [ADDR_W-1:0]        write_pointer;
    logic [ADDR_W-1:0]        read_pointer;

    logic                     rd_valid;
    logic                     rd_ready;
    logic [ADDR_W:0]          count;
    logic                     full;
    logic                     empty;

    modport master (
        output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        output rd_ready,
        input  req0_ready, req1_ready,
        input  load_en, opcode, operand_a, operand_b, write_pointer,
        input  read_pointer, rd_valid, count, full, empty
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        input  rd_ready,
        output req0_ready, req1_ready,
        output load_en, opcode, operand_a, operand_b, write_pointer,
        output read_pointer, rd_valid, count, full, empty
    );
endinterface

// File: rtl/instr_register_ctrl.sv
// ---------------------------------------------------------------------------
// instr_register_ctrl
// Write/read sequencer and round-robin arbiter for two requesters in front
// of the instr_register datapath. Accepted instructions are registered and
// presented with load_en/write_pointer for one cycle; the read side walks
// the entries in order as a FIFO cursor for a single consumer.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   flush   : synchronous clear of pointers, occupancy and pending write
//   bus     : instr_register_ctrl_if.slave (requesters, register write
//             port, read cursor, occupancy status)
// ---------------------------------------------------------------------------
module instr_register_ctrl #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 4,
    parameter int OPD_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    instr_register_ctrl_if.slave  bus
);
    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_e;

    logic                    load_en_q, load_en_d;
    logic [OPC_W-1:0]        opcode_q, opcode_d;
    logic signed [OPD_W-1:0] operand_a_q, operand_a_d;
    logic signed [OPD_W-1:0] operand_b_q, operand_b_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]         count_q, count_d;
    prio_e                   rr_prio_q, rr_prio_d;

    logic                    can_accept;
    logic                    grant_valid;
    prio_e                   grant;
    logic                    handshake;
    logic                    pop;
    logic [ADDR_W+1:0]       occupancy;

    // The write still in the load stage already owns a slot; pops in the
    // same cycle are not credited, which keeps the check conservative.
    assign occupancy  = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, load_en_q};
    // Gating with reset_n keeps both readys low while reset is held.
    assign can_accept = reset_n && !flush && (occupancy < DEPTH_EXT);

    always_comb begin
        grant       = PRIO_REQ0;
        grant_valid = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant       = rr_prio_q;
            grant_valid = 1'b1;
        end else if (bus.req0_valid) begin
            grant       = PRIO_REQ0;
            grant_valid = 1'b1;
        end else if (bus.req1_valid) begin
            grant       = PRIO_REQ1;
            grant_valid = 1'b1;
        end
    end

    assign bus.req0_ready = can_accept && grant_valid && (grant == PRIO_REQ0);
    assign bus.req1_ready = can_accept && grant_valid && (grant == PRIO_REQ1);
    assign handshake      = can_accept && grant_valid;
    assign pop            = (count_q != '0) && bus.rd_ready;

    always_comb begin
        load_en_d   = handshake;
        opcode_d    = opcode_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        rr_prio_d   = rr_prio_q;
        // load_en_q high means the register writes the entry at this edge.
        wr_ptr_d    = wr_ptr_q + ADDR_W'(load_en_q);
        rd_ptr_d    = rd_ptr_q + ADDR_W'(pop);
        count_d     = count_q + (ADDR_W+1)'(load_en_q) - (ADDR_W+1)'(pop);

        if (handshake) begin
            if (grant == PRIO_REQ0) begin
                opcode_d    = bus.req0_opcode;
                operand_a_d = bus.req0_operand_a;
                operand_b_d = bus.req0_operand_b;
                rr_prio_d   = PRIO_REQ1;
            end else begin
                opcode_d    = bus.req1_opcode;
                operand_a_d = bus.req1_operand_a;
                operand_b_d = bus.req1_operand_b;
                rr_prio_d   = PRIO_REQ0;
            end
        end

        // A commit landing on the flush edge is dropped with the rest.
        if (flush) begin
            load_en_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_en_q   <= 1'b0;
            opcode_q    <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rr_prio_q   <= PRIO_REQ0;
        end else begin
            load_en_q   <= load_en_d;
            opcode_q    <= opcode_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_prio_q   <= rr_prio_d;
        end
    end

    assign bus.load_en       = load_en_q;
    assign bus.opcode        = opcode_q;
    assign bus.operand_a     = operand_a_q;
    assign bus.operand_b     = operand_b_q;
    assign bus.write_pointer = wr_ptr_q;
    assign bus.read_pointer  = rd_ptr_q;
    assign bus.count         = count_q;
    assign bus.full          = (count_q == DEPTH_CNT);
    assign bus.empty         = (count_q == '0);
    assign bus.rd_valid      = (count_q != '0);
endmodule

// File: tb/tb_instr_register_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_register_ctrl
// Drives two requesters and a consumer around instr_register_ctrl. A small
// register-file model captures writes from the load stage; every accepted
// instruction is pushed to a scoreboard queue and compared, in order, with
// the entry at read_pointer when the consumer pops it.
// ---------------------------------------------------------------------------
module tb_instr_register_ctrl;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int OPC_W  = 4;
    localparam int OPD_W  = 32;

    typedef logic [OPC_W+2*OPD_W-1:0] word_t;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    word_t exp_q[$];
    word_t mem [DEPTH];

    instr_register_ctrl_if #(.ADDR_W(ADDR_W), .OPC_W(OPC_W), .OPD_W(OPD_W)) ifc ();

    instr_register_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .OPD_W(OPD_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;

    // Register-file model and scoreboard push on each accepted request.
    always @(posedge clk) begin
        if (reset_n) begin
            if (ifc.load_en)
                mem[ifc.write_pointer] <= {ifc.opcode, ifc.operand_a, ifc.operand_b};
            if (ifc.req0_valid && ifc.req0_ready)
                exp_q.push_back({ifc.req0_opcode, ifc.req0_operand_a, ifc.req0_operand_b});
            else if (ifc.req1_valid && ifc.req1_ready)
                exp_q.push_back({ifc.req1_opcode, ifc.req1_operand_a, ifc.req1_operand_b});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
        ifc.rd_ready   = 1'b0;
        flush          = 1'b0;
        reset_n        = 1'b0;
        #2;
        reset_n        = 1'b1;
        exp_q.delete();
    endtask

    task automatic set_req0(input int op, input int a, input int b);
        ifc.req0_opcode    = OPC_W'(op);
        ifc.req0_operand_a = OPD_W'(a);
        ifc.req0_operand_b = OPD_W'(b);
    endtask

    task automatic set_req1(input int op, input int a, input int b);
        ifc.req1_opcode    = OPC_W'(op);
        ifc.req1_operand_a = OPD_W'(a);
        ifc.req1_operand_b = OPD_W'(b);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; ifc.rd_ready = 1'b0;
        ifc.req0_valid = 1'b1; ifc.req1_valid = 1'b1;
        set_req0(1, 1, 1); set_req1(2, 2, 2);
        tick(); tick();
        checks++; if (ifc.load_en !== 1'b0) begin errors++; $display("FAIL rst_load_en: got %0b expected 0", ifc.load_en); end
        checks++; if (ifc.opcode !== 4'd0) begin errors++; $display("FAIL rst_opcode: got %0h expected 0", ifc.opcode); end
        checks++; if (ifc.operand_a !== 32'sd0) begin errors++; $display("FAIL rst_operand_a: got %0d expected 0", ifc.operand_a); end
        checks++; if (ifc.operand_b !== 32'sd0) begin errors++; $display("FAIL rst_operand_b: got %0d expected 0", ifc.operand_b); end
        checks++; if (ifc.write_pointer !== 5'd0) begin errors++; $display("FAIL rst_wp: got %0d expected 0", ifc.write_pointer); end
        checks++; if (ifc.read_pointer !== 5'd0) begin errors++; $display("FAIL rst_rp: got %0d expected 0", ifc.read_pointer); end
        checks++; if (ifc.count !== 6'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", ifc.count); end
        checks++; if (ifc.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b expected 1", ifc.empty); end
        checks++; if (ifc.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b expected 0", ifc.full); end
        checks++; if (ifc.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %0b expected 0", ifc.rd_valid); end
        checks++; if (ifc.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %0b expected 0", ifc.req0_ready); end
        checks++; if (ifc.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %0b expected 0", ifc.req1_ready); end
        ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifc.load_en !== 1'b0) begin errors++; $display("FAIL idle_load_en cyc%0d: got %0b expected 0", i, ifc.load_en); end
        end
        checks++; if (ifc.count !== 6'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", ifc.count); end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_drain();
        word_t w;
        int    guard = 0;
        tick();
        while (exp_q.size() > 0 && guard < 100) begin
            guard++;
            checks++;
            if (ifc.rd_valid !== 1'b1) begin
                errors++; $display("FAIL drain_rd_valid: got %0b expected 1 (%0d pending)", ifc.rd_valid, exp_q.size());
                break;
            end
            checks++;
            if (mem[ifc.read_pointer] !== exp_q[0]) begin
                errors++; $display("FAIL drain_word rp=%0d: got %h expected %h", ifc.read_pointer, mem[ifc.read_pointer], exp_q[0]);
            end
            ifc.rd_ready = 1'b1;
            tick();
            w = exp_q.pop_front();
            $display("pop word=%h", w);
        end
        ifc.rd_ready = 1'b0;
        exp_q.delete();
        checks++; if (ifc.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", ifc.empty); end
        checks++; if (ifc.count !== 6'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", ifc.count); end
        checks++; if (ifc.rd_valid !== 1'b0) begin errors++; $display("FAIL drain_rd_valid_end: got %0b expected 0", ifc.rd_valid); end
    endtask

    task automatic test_single_write();
        word_t exp_w;
        exp_w = {4'd3, 32'sd5, -32'sd2};
        set_req0(3, 5, -2);
        ifc.req0_valid = 1'b1;
        #1;
        checks++; if (ifc.req0_ready !== 1'b1) begin errors++; $display("FAIL sw_ready0: got %0b expected 1", ifc.req0_ready); end
        checks++; if (ifc.req1_ready !== 1'b0) begin errors++; $display("FAIL sw_ready1: got %0b expected 0", ifc.req1_ready); end
        tick();
        ifc.req0_valid = 1'b0;
        checks++; if (ifc.load_en !== 1'b1) begin errors++; $display("FAIL sw_load_en: got %0b expected 1", ifc.load_en); end
        checks++; if (ifc.write_pointer !== 5'd0) begin errors++; $display("FAIL sw_wp: got %0d expected 0", ifc.write_pointer); end
        checks++; if ({ifc.opcode, ifc.operand_a, ifc.operand_b} !== exp_w) begin errors++; $display("FAIL sw_payload: got %h expected %h", {ifc.opcode, ifc.operand_a, ifc.operand_b}, exp_w); end
        checks++; if (ifc.rd_valid !== 1'b0) begin errors++; $display("FAIL sw_rd_valid_early: got %0b expected 0", ifc.rd_valid); end
        tick();
        checks++; if (ifc.load_en !== 1'b0) begin errors++; $display("FAIL sw_load_en_drop: got %0b expected 0", ifc.load_en); end
        checks++; if (ifc.count !== 6'd1) begin errors++; $display("FAIL sw_count: got %0d expected 1", ifc.count); end
        checks++; if (ifc.rd_valid !== 1'b1) begin errors++; $display("FAIL sw_rd_valid: got %0b expected 1", ifc.rd_valid); end
        checks++; if (ifc.read_pointer !== 5'd0) begin errors++; $display("FAIL sw_rp: got %0d expected 0", ifc.read_pointer); end
        checks++; if (mem[0] !== exp_w) begin errors++; $display("FAIL sw_word: got %h expected %h", mem[0], exp_w); end
        $display("test_single_write done: errors=%0d", errors);
    endtask

    task automatic test_round_robin();
        apply_reset();
        ifc.req0_valid = 1'b1; ifc.req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_req0(k + 4, k * 10 + 1, -(k * 10 + 1));
            set_req1(k + 8, k * 10 + 2, -(k * 10 + 2));
            #1;
            checks++; if (ifc.req0_ready !== ((k % 2) == 0)) begin errors++; $display("FAIL rr_ready0 k%0d: got %0b expected %0b", k, ifc.req0_ready, (k % 2) == 0); end
            checks++; if (ifc.req1_ready !== ((k % 2) == 1)) begin errors++; $display("FAIL rr_ready1 k%0d: got %0b expected %0b", k, ifc.req1_ready, (k % 2) == 1); end
            tick();
            checks++; if (ifc.load_en !== 1'b1) begin errors++; $display("FAIL rr_load_en k%0d: got %0b expected 1", k, ifc.load_en); end
            checks++; if (ifc.write_pointer !== 5'(k)) begin errors++; $display("FAIL rr_wp k%0d: got %0d expected %0d", k, ifc.write_pointer, k); end
        end
        ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
        tick();
        checks++; if (ifc.count !== 6'd4) begin errors++; $display("FAIL rr_count: got %0d expected 4", ifc.count); end
        test_drain();
        $display("test_round_robin done: errors=%0d", errors);
    endtask

    task automatic test_fill_full();
        word_t w;
        apply_reset();
        ifc.req0_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_req0(i, i, -i);
            #1;
            checks++; if (ifc.req0_ready !== 1'b1) begin errors++; $display("FAIL fill_ready i%0d: got %0b expected 1", i, ifc.req0_ready); end
            tick();
        end
        set_req0(15, 33, -33);
        #1;
        checks++; if (ifc.req0_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_last_slot: got %0b expected 0", ifc.req0_ready); end
        tick();
        checks++; if (ifc.count !== 6'd32) begin errors++; $display("FAIL fill_count: got %0d expected 32", ifc.count); end
        checks++; if (ifc.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", ifc.full); end
        checks++; if (ifc.req0_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %0b expected 0", ifc.req0_ready); end
        tick();
        checks++; if (ifc.req0_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_hold: got %0b expected 0", ifc.req0_ready); end
        checks++; if (mem[ifc.read_pointer] !== exp_q[0]) begin errors++; $display("FAIL fill_first_word: got %h expected %h", mem[ifc.read_pointer], exp_q[0]); end
        ifc.rd_ready = 1'b1;
        #1;
        checks++; if (ifc.req0_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_pending_pop: got %0b expected 0", ifc.req0_ready); end
        tick();
        w = exp_q.pop_front();
        $display("pop word=%h", w);
        ifc.rd_ready = 1'b0;
        #1;
        checks++; if (ifc.count !== 6'd31) begin errors++; $display("FAIL fill_count_after_pop: got %0d expected 31", ifc.count); end
        checks++; if (ifc.read_pointer !== 5'd1) begin errors++; $display("FAIL fill_rp_after_pop: got %0d expected 1", ifc.read_pointer); end
        checks++; if (ifc.req0_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop: got %0b expected 1", ifc.req0_ready); end
        tick();
        ifc.req0_valid = 1'b0;
        checks++; if (ifc.load_en !== 1'b1) begin errors++; $display("FAIL wrap_load_en: got %0b expected 1", ifc.load_en); end
        checks++; if (ifc.write_pointer !== 5'd0) begin errors++; $display("FAIL wrap_wp: got %0d expected 0", ifc.write_pointer); end
        test_drain();
        checks++; if (ifc.read_pointer !== 5'd1) begin errors++; $display("FAIL wrap_rp_end: got %0d expected 1", ifc.read_pointer); end
        checks++; if (ifc.write_pointer !== 5'd1) begin errors++; $display("FAIL wrap_wp_end: got %0d expected 1", ifc.write_pointer); end
        $display("test_fill_full done: errors=%0d", errors);
    endtask

    task automatic test_simultaneous();
        word_t w;
        apply_reset();
        ifc.req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req1(i + 1, 100 + i, -(100 + i));
            tick();
        end
        ifc.req1_valid = 1'b0;
        tick();
        checks++; if (ifc.count !== 6'd10) begin errors++; $display("FAIL sim_count_pre: got %0d expected 10", ifc.count); end
        checks++; if (ifc.write_pointer !== 5'd10) begin errors++; $display("FAIL sim_wp_pre: got %0d expected 10", ifc.write_pointer); end
        set_req0(10, 77, -77);
        ifc.req0_valid = 1'b1;
        #1;
        checks++; if (ifc.req0_ready !== 1'b1) begin errors++; $display("FAIL sim_ready0: got %0b expected 1", ifc.req0_ready); end
        tick();
        ifc.req0_valid = 1'b0;
        checks++; if (ifc.load_en !== 1'b1) begin errors++; $display("FAIL sim_load_en: got %0b expected 1", ifc.load_en); end
        checks++; if (mem[ifc.read_pointer] !== exp_q[0]) begin errors++; $display("FAIL sim_word: got %h expected %h", mem[ifc.read_pointer], exp_q[0]); end
        ifc.rd_ready = 1'b1;
        tick();
        w = exp_q.pop_front();
        $display("pop word=%h", w);
        ifc.rd_ready = 1'b0;
        checks++; if (ifc.count !== 6'd10) begin errors++; $display("FAIL sim_count: got %0d expected 10", ifc.count); end
        checks++; if (ifc.write_pointer !== 5'd11) begin errors++; $display("FAIL sim_wp: got %0d expected 11", ifc.write_pointer); end
        checks++; if (ifc.read_pointer !== 5'd1) begin errors++; $display("FAIL sim_rp: got %0d expected 1", ifc.read_pointer); end
        test_drain();
        $display("test_simultaneous done: errors=%0d", errors);
    endtask

    task automatic test_flush();
        apply_reset();
        ifc.req0_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req0(i, 200 + i, -(200 + i));
            tick();
        end
        checks++; if (ifc.count !== 6'd7) begin errors++; $display("FAIL fl_count_pre: got %0d expected 7", ifc.count); end
        checks++; if (ifc.load_en !== 1'b1) begin errors++; $display("FAIL fl_load_en_pre: got %0b expected 1", ifc.load_en); end
        set_req1(9, 300, -300);
        ifc.req1_valid = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (ifc.req0_ready !== 1'b0) begin errors++; $display("FAIL fl_ready0: got %0b expected 0", ifc.req0_ready); end
        checks++; if (ifc.req1_ready !== 1'b0) begin errors++; $display("FAIL fl_ready1: got %0b expected 0", ifc.req1_ready); end
        tick();
        flush = 1'b0;
        exp_q.delete();
        checks++; if (ifc.count !== 6'd0) begin errors++; $display("FAIL fl_count: got %0d expected 0", ifc.count); end
        checks++; if (ifc.write_pointer !== 5'd0) begin errors++; $display("FAIL fl_wp: got %0d expected 0", ifc.write_pointer); end
        checks++; if (ifc.read_pointer !== 5'd0) begin errors++; $display("FAIL fl_rp: got %0d expected 0", ifc.read_pointer); end
        checks++; if (ifc.empty !== 1'b1) begin errors++; $display("FAIL fl_empty: got %0b expected 1", ifc.empty); end
        checks++; if (ifc.load_en !== 1'b0) begin errors++; $display("FAIL fl_load_en: got %0b expected 0", ifc.load_en); end
        #1;
        // Last grant before the flush went to req0, so req1 holds priority.
        checks++; if (ifc.req1_ready !== 1'b1) begin errors++; $display("FAIL fl_prio_ready1: got %0b expected 1", ifc.req1_ready); end
        checks++; if (ifc.req0_ready !== 1'b0) begin errors++; $display("FAIL fl_prio_ready0: got %0b expected 0", ifc.req0_ready); end
        tick();
        ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
        checks++; if (ifc.write_pointer !== 5'd0) begin errors++; $display("FAIL fl_wp_next: got %0d expected 0", ifc.write_pointer); end
        test_drain();
        $display("test_flush done: errors=%0d", errors);
    endtask

    task automatic test_reset_mid();
        ifc.req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req0(i + 1, 400 + i, -(400 + i));
            tick();
        end
        checks++; if (ifc.load_en !== 1'b1) begin errors++; $display("FAIL rm_load_en_pre: got %0b expected 1", ifc.load_en); end
        reset_n = 1'b0;
        #1;
        checks++; if (ifc.load_en !== 1'b0) begin errors++; $display("FAIL rm_load_en: got %0b expected 0", ifc.load_en); end
        checks++; if (ifc.count !== 6'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", ifc.count); end
        checks++; if (ifc.write_pointer !== 5'd0) begin errors++; $display("FAIL rm_wp: got %0d expected 0", ifc.write_pointer); end
        checks++; if (ifc.req0_ready !== 1'b0) begin errors++; $display("FAIL rm_ready0: got %0b expected 0", ifc.req0_ready); end
        ifc.req0_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        tick();
        checks++; if (ifc.empty !== 1'b1) begin errors++; $display("FAIL rm_empty: got %0b expected 1", ifc.empty); end
        $display("test_reset_mid done: errors=%0d", errors);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_drain();
        test_round_robin();
        test_fill_full();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
